// File: rtl/pipe_pkg.sv
// ----------------------------------------------------------------------------
// pipe_pkg
// Shared types and default widths for the pipeline stage registers.
//   pipe_state_t : occupancy of a skid-buffered stage (EMPTY / ONE / TWO)
//   PIPE_CTRL_W  : default control-field width (WB_EN, MEM_R_EN, MEM_W_EN)
//   PIPE_DATA_W  : default payload width (PC, ALU result, store value, dest)
//   PIPE_CNT_W   : default stall-counter width
// ----------------------------------------------------------------------------
package pipe_pkg;

    localparam int PIPE_CTRL_W = 3;
    localparam int PIPE_DATA_W = 101;
    localparam int PIPE_CNT_W  = 16;

    // ONE: only the main entry is full. TWO: main and skid entries are full.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pipe_state_t;

endpackage : pipe_pkg

// File: rtl/pipe_sat_counter.sv
// ----------------------------------------------------------------------------
// pipe_sat_counter
// Saturating event counter, cleared only by reset.
//   clk   : rising-edge clock
//   rst   : asynchronous active-low reset
//   inc_i : count one event this cycle
//   cnt_o : current count, sticks at 2^CNT_W-1
// ----------------------------------------------------------------------------
module pipe_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;

    // NOTE: registers are written with non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign cnt_o = cnt_q;

endmodule : pipe_sat_counter

// File: rtl/pipe_skid_reg.sv
// ----------------------------------------------------------------------------
// pipe_skid_reg
// Pipeline-stage register with a 2-entry skid buffer between two stages.
// in_ready is a function of registered state plus freeze/flush only, never of
// out_ready, so backpressure does not form a combinational path upstream.
//   clk, rst            : clock, asynchronous active-low reset
//   freeze              : hold state, entries and stall counter; no transfers
//   flush               : drop all held entries (beats freeze)
//   in_valid / in_ready : upstream handshake, in_ctrl / in_data payload
//   out_valid/out_ready : downstream handshake, out_ctrl / out_data payload
//   stall_cnt           : saturating count of out_valid & !out_ready & !freeze
// ----------------------------------------------------------------------------
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W = PIPE_CTRL_W,
    parameter int DATA_W = PIPE_DATA_W,
    parameter int CNT_W  = PIPE_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int ENTRY_W = CTRL_W + DATA_W;

    pipe_state_t        state_q, state_d;
    logic [ENTRY_W-1:0] main_q, main_d;   // {ctrl, data}, drives the outputs
    logic [ENTRY_W-1:0] skid_q, skid_d;   // {ctrl, data}, older than any later input
    logic               acc;
    logic               deq;

    // rst is folded in so upstream sees no acceptance while reset is held.
    assign in_ready  = rst && (state_q != TWO) && !freeze && !flush;
    assign out_valid = (state_q != EMPTY);

    assign acc = in_valid && in_ready;
    assign deq = out_valid && out_ready && !freeze;

    // NOTE: every always_comb output gets a default first; a path that leaves
    // one unassigned would infer a latch.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
        end else if (!freeze) begin
            unique case (state_q)
                EMPTY: begin
                    if (acc) begin
                        state_d = ONE;
                        main_d  = {in_ctrl, in_data};
                    end
                end
                ONE: begin
                    if (acc && deq) begin
                        main_d = {in_ctrl, in_data};
                    end else if (acc) begin
                        state_d = TWO;
                        skid_d  = {in_ctrl, in_data};
                    end else if (deq) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    // in_ready is low here, so only a dequeue can move us.
                    if (deq) begin
                        state_d = ONE;
                        main_d  = skid_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    // Stale main contents are masked so no control bit leaks on a bubble.
    assign out_ctrl = main_q[ENTRY_W-1:DATA_W] & {CTRL_W{out_valid}};
    assign out_data = main_q[DATA_W-1:0];

    pipe_sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (out_valid && !out_ready && !freeze),
        .cnt_o (stall_cnt)
    );

endmodule : pipe_skid_reg

// File: tb/tb_pipe_skid_reg.sv
// ----------------------------------------------------------------------------
// tb_pipe_skid_reg
// Directed bench for pipe_skid_reg. A second instance with a 2-bit stall
// counter shares all inputs so counter saturation can be observed.
// ----------------------------------------------------------------------------
module tb_pipe_skid_reg;

    localparam int CTRL_W = 3;
    localparam int DATA_W = 101;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              freeze;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  stall_cnt;

    logic              in_ready2;
    logic              out_valid2;
    logic [CTRL_W-1:0] out_ctrl2;
    logic [DATA_W-1:0] out_data2;
    logic [1:0]        stall_cnt2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pipe_skid_reg #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .freeze    (freeze),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .stall_cnt (stall_cnt)
    );

    pipe_skid_reg #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W),
        .CNT_W  (2)
    ) dut_sat (
        .clk       (clk),
        .rst       (rst),
        .freeze    (freeze),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready2),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid2),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl2),
        .out_data  (out_data2),
        .stall_cnt (stall_cnt2)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and sample shortly after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b0;
        freeze    = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_ctrl   = '0;
        in_data   = '0;
        out_ready = 1'b0;

        // Reset state while rst is held.
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_ctrl",  out_ctrl,  0);
        check("rst_out_data",  out_data,  0);
        check("rst_stall_cnt", stall_cnt, 0);
        check("rst_in_ready",  in_ready,  0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rel_in_ready", in_ready, 1);

        // Stream 1..8 at full throughput.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_ctrl   = 3'b101;
        for (int i = 1; i <= 8; i++) begin
            in_data = DATA_W'(i);
            tick();
            check("stream_valid", out_valid, 1);
            check("stream_data",  out_data,  i);
            check("stream_ctrl",  out_ctrl,  3'b101);
        end
        in_valid = 1'b0;
        tick();
        check("stream_drained", out_valid, 0);
        check("stream_ctrl0",   out_ctrl,  0);
        check("stream_stall",   stall_cnt, 0);

        // Backpressure: 0xA into main, 0xB into skid.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 3'b011;
        in_data   = DATA_W'(32'hA);
        tick();
        check("bp_a_valid", out_valid, 1);
        check("bp_a_stall", stall_cnt, 0);
        check("bp_rdy_one", in_ready,  1);
        in_data = DATA_W'(32'hB);
        tick();
        check("bp_two_rdy",   in_ready,  0);
        check("bp_stall_1",   stall_cnt, 1);
        in_valid = 1'b0;
        tick();
        check("bp_stall_2",   stall_cnt, 2);
        check("bp_hold_a",    out_data,  32'hA);
        check("bp_hold_ctrl", out_ctrl,  3'b011);
        out_ready = 1'b1;
        tick();
        check("bp_out_b",     out_data,  32'hB);
        check("bp_out_b_vld", out_valid, 1);
        check("bp_stall_keep", stall_cnt, 2);
        tick();
        check("bp_empty",     out_valid, 0);

        // Flush while in TWO with 0xC offered.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 3'b111;
        in_data   = DATA_W'(32'h1);
        tick();
        in_data = DATA_W'(32'h2);
        tick();
        check("fl_stall_3", stall_cnt, 3);
        in_data = DATA_W'(32'hC);
        flush   = 1'b1;
        #1;
        check("fl_in_ready", in_ready, 0);
        tick();
        check("fl_valid",   out_valid, 0);
        check("fl_ctrl",    out_ctrl,  0);
        check("fl_stall_4", stall_cnt, 4);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("fl_no_c", out_valid, 0);

        // Freeze with 0x5 held in main and out_ready high.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 3'b101;
        in_data   = DATA_W'(32'h5);
        tick();
        check("fz_load", out_data, 32'h5);
        in_valid  = 1'b0;
        freeze    = 1'b1;
        out_ready = 1'b1;
        #1;
        check("fz_in_ready", in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("fz_valid", out_valid, 1);
            check("fz_data",  out_data,  32'h5);
            check("fz_stall", stall_cnt, 4);
        end
        freeze = 1'b0;
        tick();
        check("fz_deq_once", out_valid, 0);
        tick();
        check("fz_stays_empty", out_valid, 0);

        // Async reset between edges while in TWO.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 3'b110;
        in_data   = DATA_W'(32'h7);
        tick();
        in_data = DATA_W'(32'h8);
        tick();
        check("ar_pre_valid", out_valid,  1);
        check("ar_pre_sat",   stall_cnt2, 3);
        #2;
        rst = 1'b0;
        #1;
        check("ar_valid",  out_valid,  0);
        check("ar_ctrl",   out_ctrl,   0);
        check("ar_data",   out_data,   0);
        check("ar_stall",  stall_cnt,  0);
        check("ar_stall2", stall_cnt2, 0);
        check("ar_rdy",    in_ready,   0);
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_ctrl  = 3'b110;
        in_data  = DATA_W'(32'h9);
        tick();
        check("ar_first_valid", out_valid, 1);
        check("ar_first_data",  out_data,  32'h9);
        check("ar_first_ctrl",  out_ctrl,  3'b110);
        check("ar_sat_data",    out_data2, 32'h9);
        check("ar_sat_ctrl",    out_ctrl2, 3'b110);
        in_valid = 1'b0;

        // Six stalled cycles: 2-bit counter saturates at 3.
        for (int k = 1; k <= 6; k++) begin
            tick();
            check("sat_cnt16", stall_cnt,  k);
            check("sat_cnt2",  stall_cnt2, (k > 3) ? 3 : k);
        end
        check("sat_valid2", out_valid2, 1);
        check("sat_rdy2",   in_ready2,  1);
        out_ready = 1'b1;
        tick();
        check("sat_drain", out_valid, 0);
        check("sat_hold",  stall_cnt2, 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_pipe_skid_reg
